// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// | Module  : counter_pkg                                                    |
// | Brief   : Direction encodings and terminal-value check for the counter.  |
// | Rev     : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Values outside 0..mod-1 never match, so a corrupt count reads as non-terminal.
  function automatic logic is_terminal(input logic [31:0] cnt,
                                       input logic        up_dn,
                                       input int unsigned mod);
    logic [31:0] top;
    top = 32'(mod - 1);
    return (up_dn == DIR_UP) ? (cnt == top) : (cnt == 32'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_updown_mod_n.sv
// ---------------------------------------------------------------------------
// | Module  : counter_updown_mod_n                                           |
// | Brief   : Modulo-N up/down counter with load, one-shot halt, tc and wrap.|
// | Rev     : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module counter_updown_mod_n
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 16,
  parameter int INIT  = MOD - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  localparam logic [WIDTH-1:0] c_MAX  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] c_INIT = WIDTH'(INIT);
  // One bit wider so MOD == 2**WIDTH is representable in the range compares.
  localparam logic [WIDTH:0]   c_MOD  = (WIDTH + 1)'(MOD);

  if ((MOD < 2) || (longint'(MOD) > (longint'(1) << WIDTH)) ||
      (INIT < 0) || (INIT >= MOD)) begin : g_bad_params
    $fatal(1, "counter_updown_mod_n: illegal WIDTH/MOD/INIT combination");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_done;
  logic [WIDTH-1:0] w_load_sat;
  logic             w_tc;

  assign w_load_sat = ({1'b0, load_val} < c_MOD) ? load_val : c_MAX;
  assign w_tc       = is_terminal(32'(r_count), up_dn, MOD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= c_INIT;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else if (load) begin
      r_count <= w_load_sat;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else if (en && !r_done) begin
      if (w_tc && oneshot) begin
        r_done <= 1'b1;
        r_wrap <= 1'b0;
      end else if (w_tc) begin
        r_count <= (up_dn == DIR_UP) ? '0 : c_MAX;
        r_wrap  <= 1'b1;
      end else begin
        r_count <= (up_dn == DIR_UP) ? r_count + 1'b1 : r_count - 1'b1;
        r_wrap  <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ({1'b0, r_count} < c_MOD);
    end
  end

  assign count = r_count;
  assign tc    = w_tc;
  assign wrap  = r_wrap;
  assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_counter_updown_mod_n.sv
// ---------------------------------------------------------------------------
// | Module  : tb_counter_updown_mod_n                                        |
// | Brief   : Directed self-checking bench for MOD-11 and MOD-16 counters.   |
// | Rev     : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_counter_updown_mod_n;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load, oneshot;
  logic [3:0] load_val;
  logic [3:0] count, count16;
  logic       tc, wrap, done, tc16, wrap16, done16;
  int         vec  = 0;
  int         errs = 0;

  always #5 clk = ~clk;

  counter_updown_mod_n #(.WIDTH(4), .MOD(11), .INIT(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .oneshot(oneshot),
    .count(count), .tc(tc), .wrap(wrap), .done(done));

  counter_updown_mod_n #(.WIDTH(4), .MOD(16), .INIT(15)) dut16 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .oneshot(oneshot),
    .count(count16), .tc(tc16), .wrap(wrap16), .done(done16));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = 4'd0; oneshot = 1'b0;
    step();
    rst = 1'b0;
    #1;
    vec++;
    if ({count, wrap, done, tc} !== {4'd10, 1'b0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL reset11: got cnt=%0d wrap=%b done=%b tc=%b, want cnt=10 wrap=0 done=0 tc=0",
               count, wrap, done, tc);
    end
    vec++;
    if ({count16, wrap16, done16} !== {4'd15, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL reset16: got cnt=%0d wrap=%b done=%b, want cnt=15 wrap=0 done=0",
               count16, wrap16, done16);
    end
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_c, prev;
    exp_c = 4'd10;
    en = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
      prev  = exp_c;
      exp_c = (prev == 4'd0) ? 4'd10 : prev - 4'd1;
      vec++;
      if ({count, wrap, tc} !== {exp_c, prev == 4'd0, exp_c == 4'd0}) begin
        errs++;
        $display("FAIL down_wrap[%0d]: got cnt=%0d wrap=%b tc=%b, want cnt=%0d wrap=%b tc=%b",
                 i, count, wrap, tc, exp_c, prev == 4'd0, exp_c == 4'd0);
      end
    end
  endtask

  task automatic test_up_wrap_dir();
    logic [3:0] exp_seq [3] = '{4'd9, 4'd10, 4'd0};
    en = 1'b0; load = 1'b1; load_val = 4'd8;
    step();
    load = 1'b0;
    vec++;
    if (count !== 4'd8) begin
      errs++; $display("FAIL load8: got %0d want 8", count);
    end
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vec++;
      if ({count, wrap, tc} !== {exp_seq[i], i == 2, i == 1}) begin
        errs++;
        $display("FAIL up_wrap[%0d]: got cnt=%0d wrap=%b tc=%b, want cnt=%0d wrap=%b tc=%b",
                 i, count, wrap, tc, exp_seq[i], i == 2, i == 1);
      end
    end
    up_dn = 1'b0;
    #1;
    vec++;
    if (tc !== 1'b1) begin
      errs++; $display("FAIL tc_dir_change: got %b want 1", tc);
    end
    step();
    vec++;
    if ({count, wrap} !== {4'd10, 1'b1}) begin
      errs++; $display("FAIL dir_wrap: got cnt=%0d wrap=%b, want cnt=10 wrap=1", count, wrap);
    end
  endtask

  task automatic test_load_priority();
    en = 1'b1; up_dn = 1'b0; load = 1'b1; load_val = 4'd5;
    step();
    vec++;
    if ({count, wrap} !== {4'd5, 1'b0}) begin
      errs++; $display("FAIL load_over_en: got cnt=%0d wrap=%b, want cnt=5 wrap=0", count, wrap);
    end
    load_val = 4'd15;
    step();
    load = 1'b0;
    vec++;
    if (count !== 4'd10) begin
      errs++; $display("FAIL load_sat: got %0d want 10", count);
    end
  endtask

  task automatic test_oneshot();
    en = 1'b1; up_dn = 1'b0; oneshot = 1'b1; load = 1'b1; load_val = 4'd2;
    step();
    load = 1'b0;
    step();
    vec++;
    if ({count, done} !== {4'd1, 1'b0}) begin
      errs++; $display("FAIL os_1: got cnt=%0d done=%b, want cnt=1 done=0", count, done);
    end
    step();
    vec++;
    if ({count, done} !== {4'd0, 1'b0}) begin
      errs++; $display("FAIL os_0: got cnt=%0d done=%b, want cnt=0 done=0", count, done);
    end
    for (int i = 0; i < 10; i++) begin
      up_dn = (i >= 5);  // frozen even when the direction would allow a step
      step();
      vec++;
      if ({count, done, wrap} !== {4'd0, 1'b1, 1'b0}) begin
        errs++;
        $display("FAIL os_hold[%0d]: got cnt=%0d done=%b wrap=%b, want cnt=0 done=1 wrap=0",
                 i, count, done, wrap);
      end
    end
    up_dn = 1'b0; load = 1'b1; load_val = 4'd7;
    step();
    load = 1'b0;
    vec++;
    if ({count, done} !== {4'd7, 1'b0}) begin
      errs++; $display("FAIL os_reload: got cnt=%0d done=%b, want cnt=7 done=0", count, done);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      vec++;
      if (count !== 4'(6 - i)) begin
        errs++; $display("FAIL os_resume[%0d]: got %0d want %0d", i, count, 6 - i);
      end
    end
    oneshot = 1'b0;
  endtask

  task automatic test_enable_gating();
    logic [3:0] exp_c;
    up_dn = 1'b0; load = 1'b1; load_val = 4'd5;
    step();
    load = 1'b0;
    exp_c = 4'd5;
    for (int i = 0; i < 4; i++) begin
      en = i[0];
      step();
      if (en) exp_c = exp_c - 4'd1;
      vec++;
      if ({count, wrap} !== {exp_c, 1'b0}) begin
        errs++; $display("FAIL en_gate[%0d]: got cnt=%0d wrap=%b, want cnt=%0d wrap=0",
                         i, count, wrap, exp_c);
      end
    end
    en = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
    vec++;
    if ({count, wrap, done} !== {4'd10, 1'b0, 1'b0}) begin
      errs++; $display("FAIL mid_rst: got cnt=%0d wrap=%b done=%b, want cnt=10 wrap=0 done=0",
                       count, wrap, done);
    end
  endtask

  task automatic test_full_range();
    logic [3:0] exp_c, prev;
    en = 1'b0; rst = 1'b1; up_dn = 1'b0; oneshot = 1'b0;
    step();
    rst = 1'b0; en = 1'b1;
    exp_c = 4'd15;
    for (int i = 0; i < 40; i++) begin
      step();
      prev  = exp_c;
      exp_c = (prev == 4'd0) ? 4'd15 : prev - 4'd1;
      vec++;
      if ({count16, wrap16, tc16} !== {exp_c, prev == 4'd0, exp_c == 4'd0}) begin
        errs++;
        $display("FAIL full16[%0d]: got cnt=%0d wrap=%b tc=%b, want cnt=%0d wrap=%b tc=%b",
                 i, count16, wrap16, tc16, exp_c, prev == 4'd0, exp_c == 4'd0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_down_wrap();
    test_up_wrap_dir();
    test_load_priority();
    test_oneshot();
    test_enable_gating();
    test_full_range();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/counter_updown_mod_n.md
Name: counter_updown_mod_n

Overview:
Parametrised modulo-N up/down counter. Generalises the fixed 4-bit MOD-16 down counter with:
- configurable width and modulus;
- run-time direction, enable and parallel load;
- a one-shot mode;
- terminal-count and wrap status outputs.
Used as the common timing/sequencing counter across the design.

Parameters:
WIDTH, 4, count register width in bits
MOD, 16, modulus; count range is 0..MOD-1; legal range 2 <= MOD <= 2**WIDTH
INIT, MOD-1, value loaded on reset; legal range INIT < MOD

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
en  input  1  count enable; one step per enabled rising edge
up_dn  input  1  direction: 1 = up, 0 = down; sampled on every edge
load  input  1  parallel load strobe
load_val  input  WIDTH  value to load
oneshot  input  1  1 = halt at terminal value instead of wrapping
count  output  WIDTH  current count (registered)
tc  output  1  terminal count, combinational: (up_dn && count==MOD-1) || (!up_dn && count==0)
wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap edge
done  output  1  sticky flag, one-shot halt reached

Behaviour:
- One clock domain. Reset is synchronous and active-high; all state updates on rising clk.
- Reset values: count=INIT, wrap=0, done=0. tc follows from count and up_dn.
- Priority per edge: rst > load > en. With none of these active, count holds and wrap=0.
- load:
  - count <= load_val if load_val < MOD, else count <= MOD-1 (saturate).
  - Clears done; wrap=0 that cycle.
  - Load overrides en in the same cycle.
- en=1, done=0, not at terminal value:
  - up: count <= count+1; down: count <= count-1.
  - wrap <= 0.
- en=1, done=0, at terminal value, oneshot=0 (wrap):
  - up: MOD-1 -> 0; down: 0 -> MOD-1.
  - wrap <= 1 for exactly one cycle.
  - The terminal value is visible on count for one full enabled cycle before the wrap (down: ..., 1, 0, MOD-1, ...).
- en=1, done=0, at terminal value, oneshot=1 (halt):
  - count holds; done <= 1; wrap stays 0.
- done=1:
  - count frozen regardless of en and up_dn.
  - Only load or rst releases it.
- Direction change mid-count takes effect on the next enabled edge. No jump and no wrap pulse.
- Terminal value is always evaluated against the current up_dn at the edge.
- If count lies outside 0..MOD-1 (only possible through a bad INIT), it is treated as non-terminal. An assertion catches this.
- en=0: count, done hold; wrap=0.
- Reset mid-operation (including during a wrap or done=1) returns to reset values on that edge.
- Width rules:
  - Arithmetic is WIDTH bits.
  - MOD-1 is computed as a WIDTH-bit constant.
  - When MOD == 2**WIDTH, the wrap equals natural overflow, but the explicit compare is still used.
- Elaboration checks: MOD >= 2, MOD <= 2**WIDTH, INIT < MOD. A violation stops elaboration with a fatal error.
- Latency: count reflects an enable, load or reset one edge later. tc is combinational from count and up_dn. wrap aligns with the wrapped count value.

Decomposition:
- Package counter_pkg holds:
  - DIR_UP=1'b1 and DIR_DOWN=1'b0;
  - a function for the terminal-value check (count, up_dn, MOD).
- No sub-module. The next-value mux and flags form one always block plus a tc assign.

Test Plan:
- Reset and down-wrap: WIDTH=4, MOD=11, INIT=10; rst 1 cycle, en=1, up_dn=0 → count 10,9,...,1,0,10. tc high only while count=0; wrap high on the single cycle count returns to 10.
- Up-wrap and direction change: MOD=11; load 8, up_dn=1, en → 9,10,0 (wrap pulse, tc at 10). Set up_dn=0 while count=0 → next value 10, with wrap pulse.
- Load priority and saturation: load=1 with en=1, load_val=5 → count=5, no step. Then load_val=15 with MOD=11 → count=10.
- One-shot: oneshot=1, down, load 2 → 1, 0, then count holds 0 and done=1 for 10 cycles with en=1, wrap never high. Load 7 → done=0, counting resumes 6, 5, ....
- Enable gating and mid-run reset: toggle en every other cycle → count steps only on en=1 edges. Assert rst while count=3, en=1 → next count=10, wrap=0, done=0.
- Full-range case: WIDTH=4, MOD=16, INIT=15, down for 40 cycles → sequence 15..0 repeating, wrap every 16 cycles. Compare against a reference model.
